packet_loader: RTL and testbench

- Consumes packet-requests (from startup and other requesters) and fetches the addressed instruction word from instruction memory.
- Assembles the word and the request operands into one packet and hands it to the execution side.
- Single outstanding fetch: one request in flight at a time, with back-pressure in both directions.

---
 rtl/packet_loader_pkg.sv | 90 +++++++++
 rtl/packet_loader_if.sv | 38 +++
 rtl/packet_loader.sv | 108 ++++++++++
 tb/tb_packet_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/packet_loader_pkg.sv
// Shared types, widths and packet helpers for the packet loader.
// Request and packet layouts are MSB-first, in the field order of the structs below.
package packet_loader_pkg;

  localparam int unsigned INST_WIDTH           = 32;
  localparam int unsigned PACKET_REQUEST_WIDTH = 98;
  localparam int unsigned PACKET_WIDTH         = 130;

  localparam logic [1:0] DEST_OPTION_NONE  = 2'd0;
  localparam logic [1:0] DEST_OPTION_EXEC  = 2'd1;
  localparam logic [1:0] DEST_OPTION_LOAD  = 2'd2;
  localparam logic [1:0] DEST_OPTION_STORE = 2'd3;

  localparam int unsigned PR_DEST_LSB   = 96;
  localparam int unsigned PR_ADDR_LSB   = 80;
  localparam int unsigned PR_COLOR_LSB  = 64;
  localparam int unsigned PR_DATA1_LSB  = 32;
  localparam int unsigned PR_DATA2_LSB  = 0;

  localparam int unsigned PKT_DEST_LSB  = 128;
  localparam int unsigned PKT_COLOR_LSB = 112;
  localparam int unsigned PKT_DATA1_LSB = 80;
  localparam int unsigned PKT_DATA2_LSB = 48;
  localparam int unsigned PKT_INST_LSB  = 16;
  localparam int unsigned PKT_ADDR_LSB  = 0;

  typedef struct packed {
    logic [1:0]  dest_option;
    logic [15:0] inst_addr;
    logic [15:0] color;
    logic [31:0] data1;
    logic [31:0] data2;
  } packet_request_t;

  typedef struct packed {
    logic [1:0]            dest_option;
    logic [15:0]           color;
    logic [31:0]           data1;
    logic [31:0]           data2;
    logic [INST_WIDTH-1:0] instruction;
    logic [15:0]           inst_addr;
  } packet_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MREQ,
    S_MWAIT,
    S_SEND
  } state_e;

  function automatic packet_t make_packet(input packet_request_t req,
                                          input logic [INST_WIDTH-1:0] inst);
    packet_t p;
    p.dest_option = req.dest_option;
    p.color       = req.color;
    p.data1       = req.data1;
    p.data2       = req.data2;
    p.instruction = inst;
    p.inst_addr   = req.inst_addr;
    return p;
  endfunction

  // Word index to byte address; the sum wraps modulo 2^32.
  function automatic logic [31:0] inst_byte_addr(input logic [31:0] base,
                                                 input logic [15:0] word_addr);
    return base + {14'b0, word_addr, 2'b00};
  endfunction

  // Shared rule for every registered valid: set wins, otherwise hold until the handshake.
  function automatic logic next_valid(input logic cur, input logic set, input logic fire);
    return set | (cur & ~fire);
  endfunction

  function automatic logic [1:0] pkt_dest_option(input logic [PACKET_WIDTH-1:0] p);
    return p[PKT_DEST_LSB +: 2];
  endfunction

  function automatic logic [15:0] pkt_color(input logic [PACKET_WIDTH-1:0] p);
    return p[PKT_COLOR_LSB +: 16];
  endfunction

  function automatic logic [INST_WIDTH-1:0] pkt_instruction(input logic [PACKET_WIDTH-1:0] p);
    return p[PKT_INST_LSB +: INST_WIDTH];
  endfunction

  function automatic logic [15:0] pkt_inst_addr(input logic [PACKET_WIDTH-1:0] p);
    return p[PKT_ADDR_LSB +: 16];
  endfunction

endpackage

// File: rtl/packet_loader_if.sv
// Request, memory and packet channels of the packet loader.
// master is the loader side, slave the requester/memory/consumer side.
interface packet_loader_if;
  import packet_loader_pkg::*;

  logic                            RECV_PR_VALID;
  logic [PACKET_REQUEST_WIDTH-1:0] RECV_PR_DATA;
  logic                            RECV_PR_READY;

  logic                            MEM_REQ_VALID;
  logic [31:0]                     MEM_REQ_ADDR;
  logic                            MEM_REQ_READY;
  logic                            MEM_RESP_VALID;
  logic [INST_WIDTH-1:0]           MEM_RESP_DATA;

  logic                            SEND_PACKET_VALID;
  logic [PACKET_WIDTH-1:0]         SEND_PACKET_DATA;
  logic                            SEND_PACKET_READY;

  modport master (
    input  RECV_PR_VALID, RECV_PR_DATA,
    output RECV_PR_READY,
    output MEM_REQ_VALID, MEM_REQ_ADDR,
    input  MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    output SEND_PACKET_VALID, SEND_PACKET_DATA,
    input  SEND_PACKET_READY
  );

  modport slave (
    output RECV_PR_VALID, RECV_PR_DATA,
    input  RECV_PR_READY,
    input  MEM_REQ_VALID, MEM_REQ_ADDR,
    output MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    input  SEND_PACKET_VALID, SEND_PACKET_DATA,
    output SEND_PACKET_READY
  );

endinterface

// File: rtl/packet_loader.sv
// Fetches the instruction word addressed by each packet-request and emits one packet per request.
// Single outstanding fetch; valids are registered, request ready is decoded from state.
module packet_loader
  import packet_loader_pkg::*;
#(
  parameter logic [31:0] INST_BASE = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  packet_loader_if.master   bus,
  output logic [31:0]       LOAD_COUNT
);

  state_e                r_state;
  state_e                w_state_next;
  packet_request_t       r_req;
  packet_request_t       w_req_next;
  logic [INST_WIDTH-1:0] r_inst;
  logic [INST_WIDTH-1:0] w_inst_next;
  logic                  r_mem_req_valid;
  logic                  w_mem_req_valid_next;
  logic                  r_send_valid;
  logic                  w_send_valid_next;
  logic [31:0]           r_load_count;
  logic [31:0]           w_load_count_next;

  logic w_mem_fire;
  logic w_send_fire;
  logic w_mem_req_set;
  logic w_send_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_req           <= '0;
      r_inst          <= '0;
      r_mem_req_valid <= 1'b0;
      r_send_valid    <= 1'b0;
      r_load_count    <= '0;
    end else begin
      r_state         <= w_state_next;
      r_req           <= w_req_next;
      r_inst          <= w_inst_next;
      r_mem_req_valid <= w_mem_req_valid_next;
      r_send_valid    <= w_send_valid_next;
      r_load_count    <= w_load_count_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_req_next        = r_req;
    w_inst_next       = r_inst;
    w_load_count_next = r_load_count;
    w_mem_req_set     = 1'b0;
    w_send_set        = 1'b0;
    w_mem_fire        = r_mem_req_valid & bus.MEM_REQ_READY;
    w_send_fire       = r_send_valid & bus.SEND_PACKET_READY;

    unique case (r_state)
      S_IDLE: begin
        if (bus.RECV_PR_VALID) begin
          w_req_next   = packet_request_t'(bus.RECV_PR_DATA);
          w_state_next = S_MREQ;
        end
      end
      S_MREQ: begin
        if (w_mem_fire) begin
          // A response landing on the handshake cycle skips the wait state.
          if (bus.MEM_RESP_VALID) begin
            w_inst_next  = bus.MEM_RESP_DATA;
            w_send_set   = 1'b1;
            w_state_next = S_SEND;
          end else begin
            w_state_next = S_MWAIT;
          end
        end else begin
          w_mem_req_set = 1'b1;
        end
      end
      S_MWAIT: begin
        if (bus.MEM_RESP_VALID) begin
          w_inst_next  = bus.MEM_RESP_DATA;
          w_send_set   = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_send_fire) begin
          w_load_count_next = r_load_count + 32'd1;
          w_state_next      = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_mem_req_valid_next = next_valid(r_mem_req_valid, w_mem_req_set, w_mem_fire);
    w_send_valid_next    = next_valid(r_send_valid, w_send_set, w_send_fire);
  end

  assign bus.RECV_PR_READY     = (r_state == S_IDLE);
  assign bus.MEM_REQ_VALID     = r_mem_req_valid;
  assign bus.MEM_REQ_ADDR      = inst_byte_addr(INST_BASE, r_req.inst_addr);
  assign bus.SEND_PACKET_VALID = r_send_valid;
  assign bus.SEND_PACKET_DATA  = make_packet(r_req, r_inst);
  assign LOAD_COUNT            = r_load_count;

endmodule

// File: tb/tb_packet_loader.sv
// Directed bench for packet_loader: hand-computed addresses, packets, latency and counts.
module tb_packet_loader;
  import packet_loader_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] load_count;
  logic [31:0] load_count_w;

  int vectors = 0;
  int miscompares = 0;

  packet_loader_if if0 ();
  packet_loader_if if1 ();

  packet_loader #(.INST_BASE(32'h0000_0000)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (if0),
    .LOAD_COUNT (load_count)
  );

  packet_loader #(.INST_BASE(32'hFFFF_FFF0)) u_wrap (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (if1),
    .LOAD_COUNT (load_count_w)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for the memory request, accepts it, and returns the word one cycle later.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] word, output int cycles);
    int n;
    n = 1;
    tick();
    while (!if0.MEM_REQ_VALID && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_mem_valid"}, if0.MEM_REQ_VALID, 1'b1);
    check({tag, "_mem_addr"}, if0.MEM_REQ_ADDR, exp_addr);
    tick();
    check({tag, "_mem_drop"}, if0.MEM_REQ_VALID, 1'b0);
    if0.MEM_RESP_VALID = 1'b1;
    if0.MEM_RESP_DATA  = word;
    tick();
    if0.MEM_RESP_VALID = 1'b0;
    cycles = n + 2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [129:0] exp_pkt;
    logic [31:0]  addr0;
    int           cyc;

    RST = 1'b1;
    if0.RECV_PR_VALID = 1'b0;  if0.RECV_PR_DATA  = '0;
    if0.MEM_REQ_READY = 1'b1;  if0.MEM_RESP_VALID = 1'b0;
    if0.MEM_RESP_DATA = '0;    if0.SEND_PACKET_READY = 1'b1;
    if1.RECV_PR_VALID = 1'b0;  if1.RECV_PR_DATA  = '0;
    if1.MEM_REQ_READY = 1'b0;  if1.MEM_RESP_VALID = 1'b0;
    if1.MEM_RESP_DATA = '0;    if1.SEND_PACKET_READY = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    check("rst_recv_ready", if0.RECV_PR_READY, 1'b1);
    check("rst_mem_valid", if0.MEM_REQ_VALID, 1'b0);
    check("rst_send_valid", if0.SEND_PACKET_VALID, 1'b0);
    check("rst_count", load_count, 32'd0);

    // Basic fetch with latency measurement.
    if0.RECV_PR_VALID = 1'b1;
    if0.RECV_PR_DATA  = {2'd1, 16'h0003, 16'h0001, 32'h0000_0011, 32'h0000_0022};
    tick();
    if0.RECV_PR_VALID = 1'b0;
    check("basic_busy", if0.RECV_PR_READY, 1'b0);
    do_fetch("basic", 32'h0000_000C, 32'hDEAD_BEEF, cyc);
    check("basic_latency", cyc, 3);
    check("basic_send_valid", if0.SEND_PACKET_VALID, 1'b1);
    exp_pkt = {2'd1, 16'h0001, 32'h0000_0011, 32'h0000_0022, 32'hDEAD_BEEF, 16'h0003};
    check("basic_packet", if0.SEND_PACKET_DATA, exp_pkt);
    tick();
    check("basic_count", load_count, 32'd1);
    check("basic_send_drop", if0.SEND_PACKET_VALID, 1'b0);
    check("basic_idle", if0.RECV_PR_READY, 1'b1);

    // Back-pressure on both memory and consumer.
    if0.MEM_REQ_READY = 1'b0;
    if0.RECV_PR_VALID = 1'b1;
    if0.RECV_PR_DATA  = {2'd3, 16'h0010, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0};
    tick();
    if0.RECV_PR_VALID = 1'b0;
    tick();
    addr0 = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      check("bp_mem_valid", if0.MEM_REQ_VALID, 1'b1);
      check("bp_mem_addr", if0.MEM_REQ_ADDR, addr0);
      tick();
    end
    if0.MEM_REQ_READY = 1'b1;
    if0.SEND_PACKET_READY = 1'b0;
    tick();
    if0.MEM_RESP_VALID = 1'b1;
    if0.MEM_RESP_DATA  = 32'hCAFE_F00D;
    tick();
    if0.MEM_RESP_VALID = 1'b0;
    exp_pkt = {2'd3, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_F00D, 16'h0010};
    for (int i = 0; i < 7; i++) begin
      check("bp_send_valid", if0.SEND_PACKET_VALID, 1'b1);
      check("bp_packet", if0.SEND_PACKET_DATA, exp_pkt);
      check("bp_recv_ready", if0.RECV_PR_READY, 1'b0);
      tick();
    end
    if0.SEND_PACKET_READY = 1'b1;
    tick();
    check("bp_count", load_count, 32'd2);
    tick();
    tick();
    check("bp_count_once", load_count, 32'd2);
    check("bp_send_idle", if0.SEND_PACKET_VALID, 1'b0);

    // Back-to-back: B is held valid while A is in flight.
    if0.RECV_PR_VALID = 1'b1;
    if0.RECV_PR_DATA  = {2'd2, 16'h0001, 16'h0002, 32'h0000_00A1, 32'h0000_00A2};
    tick();
    if0.RECV_PR_DATA  = {2'd0, 16'h0002, 16'h0003, 32'h0000_00B1, 32'h0000_00B2};
    do_fetch("b2b_a", 32'h0000_0004, 32'h1111_0001, cyc);
    exp_pkt = {2'd2, 16'h0002, 32'h0000_00A1, 32'h0000_00A2, 32'h1111_0001, 16'h0001};
    check("b2b_a_packet", if0.SEND_PACKET_DATA, exp_pkt);
    check("b2b_a_hold_off", if0.RECV_PR_READY, 1'b0);
    tick();
    check("b2b_a_count", load_count, 32'd3);
    check("b2b_b_ready", if0.RECV_PR_READY, 1'b1);
    tick();
    if0.RECV_PR_VALID = 1'b0;
    check("b2b_b_taken", if0.RECV_PR_READY, 1'b0);
    do_fetch("b2b_b", 32'h0000_0008, 32'h2222_0002, cyc);
    exp_pkt = {2'd0, 16'h0003, 32'h0000_00B1, 32'h0000_00B2, 32'h2222_0002, 16'h0002};
    check("b2b_b_packet", if0.SEND_PACKET_DATA, exp_pkt);
    tick();
    check("b2b_b_count", load_count, 32'd4);

    // Spurious response while idle.
    if0.MEM_RESP_VALID = 1'b1;
    if0.MEM_RESP_DATA  = 32'h5555_AAAA;
    tick();
    if0.MEM_RESP_VALID = 1'b0;
    tick();
    check("spur_ready", if0.RECV_PR_READY, 1'b1);
    check("spur_send", if0.SEND_PACKET_VALID, 1'b0);
    check("spur_mem", if0.MEM_REQ_VALID, 1'b0);
    check("spur_count", load_count, 32'd4);

    // Base-address wrap on the second instance.
    if1.RECV_PR_VALID = 1'b1;
    if1.RECV_PR_DATA  = {2'd1, 16'h0005, 16'h0000, 32'h0, 32'h0};
    tick();
    if1.RECV_PR_VALID = 1'b0;
    tick();
    check("wrap_mem_valid", if1.MEM_REQ_VALID, 1'b1);
    check("wrap_addr", if1.MEM_REQ_ADDR, 32'h0000_0004);

    // Reset while waiting for memory; the late response must be dropped.
    if0.RECV_PR_VALID = 1'b1;
    if0.RECV_PR_DATA  = {2'd1, 16'h0007, 16'h0009, 32'h1, 32'h2};
    tick();
    if0.RECV_PR_VALID = 1'b0;
    tick();
    tick();
    check("mid_in_mwait", if0.MEM_REQ_VALID, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_ready", if0.RECV_PR_READY, 1'b1);
    check("mid_rst_count", load_count, 32'd0);
    if0.MEM_RESP_VALID = 1'b1;
    if0.MEM_RESP_DATA  = 32'h7777_7777;
    tick();
    if0.MEM_RESP_VALID = 1'b0;
    tick();
    tick();
    check("mid_no_packet", if0.SEND_PACKET_VALID, 1'b0);
    check("mid_ready", if0.RECV_PR_READY, 1'b1);
    check("mid_count", load_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
